// File: rtl/key_beep_pkg.sv
// key_beep_pkg: shared FSM state type, default 50 MHz timing and counter width helper
package key_beep_pkg;
  typedef enum logic [1:0] {IDLE, BEEP, GAP} state_t;
  localparam int TONE_DIV_DEF = 12500;
  localparam int BEEP_CYC_DEF = 5000000;
  localparam int GAP_CYC_DEF  = 2500000;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_beep_tone.sv
// key_beep_tone: half-period toggle divider (clk, rst, clr forces high, en runs it, tone out; 0 when disabled)
module key_beep_tone
  import key_beep_pkg::*;
#(
  parameter int TONE_DIV = TONE_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tone
);
  localparam int TW = cw(TONE_DIV);
  logic [TW-1:0] cnt_q, cnt_d;
  logic tone_q, tone_d, wrap;
  always_comb begin
    wrap   = cnt_q == TW'(TONE_DIV - 1);
    cnt_d  = (clr || !en || wrap) ? '0 : cnt_q + 1'b1;
    tone_d = clr ? 1'b1 : !en ? 1'b0 : wrap ? ~tone_q : tone_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end
  assign tone = tone_q;
endmodule

// File: rtl/key_beep.sv
// key_beep: queues key-press pulses and plays one tone burst per press (keyN_in in; beep_out, busy, pend_cnt, drop out)
module key_beep
  import key_beep_pkg::*;
#(
  parameter int TONE_DIV = TONE_DIV_DEF,
  parameter int BEEP_CYC = BEEP_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF,
  parameter int QMAX     = 3,
  parameter int QW       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key1_in,
  input  logic          key2_in,
  input  logic          key3_in,
  output logic          beep_out,
  output logic          busy,
  output logic [QW-1:0] pend_cnt,
  output logic          drop
);
  localparam int DW = cw(BEEP_CYC > GAP_CYC ? BEEP_CYC : GAP_CYC);
  localparam int SW = QW + 2;
  state_t state_q, state_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [QW-1:0] pend_q, pend_d;
  logic [SW-1:0] s;
  logic drop_q, drop_d, busy_q, busy_d;
  logic beep_end, gap_end, launch;
  always_comb begin
    beep_end = (state_q == BEEP) && (dur_q == DW'(BEEP_CYC - 1));
    gap_end  = (state_q == GAP) && (dur_q == DW'(GAP_CYC - 1));
    // launch looks only at the registered count, so same-cycle presses queue
    launch   = (pend_q != '0) && ((state_q == IDLE) || gap_end);
    s        = SW'(pend_q) + SW'(key1_in) + SW'(key2_in) + SW'(key3_in) - SW'(launch);
    pend_d   = (s > SW'(QMAX)) ? QW'(QMAX) : s[QW-1:0];
    drop_d   = s > SW'(QMAX);
    state_d  = launch ? BEEP : beep_end ? GAP : gap_end ? IDLE : state_q;
    dur_d    = ((state_d != state_q) || (state_q == IDLE)) ? '0 : dur_q + 1'b1;
    busy_d   = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dur_q   <= '0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end
  // tone only runs while the burst continues next cycle, so the last BEEP cycle hands off a silent GAP
  key_beep_tone #(.TONE_DIV(TONE_DIV)) u_tone (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .en  ((state_q == BEEP) && !beep_end),
    .tone(beep_out)
  );
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign drop     = drop_q;
endmodule

// File: tb/tb_key_beep.sv
// tb_key_beep: directed table-driven bench for key_beep with short test timing
module tb_key_beep;
  typedef struct {
    logic [2:0] k;
    logic       beep;
    logic       busy;
    logic [1:0] pend;
    logic       drop;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic key1_in = 1'b0, key2_in = 1'b0, key3_in = 1'b0;
  logic beep_out, busy, drop;
  logic [1:0] pend_cnt;
  logic [7:0] pat = 8'b00110011;
  vec_t tv[$];
  int errors = 0, checks = 0;
  key_beep #(.TONE_DIV(2), .BEEP_CYC(8), .GAP_CYC(4), .QMAX(3), .QW(2)) dut (
    .clk(clk), .rst(rst), .key1_in(key1_in), .key2_in(key2_in), .key3_in(key3_in),
    .beep_out(beep_out), .busy(busy), .pend_cnt(pend_cnt), .drop(drop)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got beep=%b busy=%b pend=%0d drop=%b, want beep=%b busy=%b pend=%0d drop=%b",
               name, got[4], got[3], got[2:1], got[0], want[4], want[3], want[2:1], want[0]);
    end
  endtask
  task automatic push(input logic [2:0] k, input logic b, input logic bz, input logic [1:0] p, input logic d);
    tv.push_back('{k, b, bz, p, d});
  endtask
  task automatic idle(input int n);
    repeat (n) push(3'b000, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask
  task automatic burst(input logic [1:0] p, input int from);
    for (int j = from; j < 8; j++) push(3'b000, pat[j], 1'b1, p, 1'b0);
  endtask
  task automatic gap(input logic [1:0] p, input int n);
    repeat (n) push(3'b000, 1'b0, 1'b1, p, 1'b0);
  endtask
  task automatic do_reset();
    {key3_in, key2_in, key1_in} = 3'b000;
    rst = 1'b1;
    #1;
    check("reset", {beep_out, busy, pend_cnt, drop}, 5'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic run(input string name);
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk);
      #1 {key3_in, key2_in, key1_in} = tv[i].k;
      @(negedge clk);
      check($sformatf("%s cyc%0d", name, i), {beep_out, busy, pend_cnt, drop},
            {tv[i].beep, tv[i].busy, tv[i].pend, tv[i].drop});
    end
    {key3_in, key2_in, key1_in} = 3'b000;
    tv.delete();
  endtask
  initial begin
    do_reset();
    idle(10); push(3'b001, 0, 0, 0, 0); push(3'b000, 0, 0, 1, 0);
    burst(0, 0); gap(0, 4); idle(2);
    run("single");
    do_reset();
    push(3'b111, 0, 0, 0, 0); push(3'b000, 0, 0, 3, 0);
    burst(2, 0); gap(2, 4); burst(1, 0); gap(1, 4); burst(0, 0); gap(0, 4); idle(2);
    run("simul");
    do_reset();
    push(3'b111, 0, 0, 0, 0); push(3'b000, 0, 0, 3, 0);
    push(3'b111, 1, 1, 2, 0); push(3'b000, 1, 1, 3, 1);
    burst(3, 2); gap(3, 4); burst(2, 0); gap(2, 4); burst(1, 0); gap(1, 4); burst(0, 0); gap(0, 4); idle(2);
    run("sat");
    do_reset();
    push(3'b111, 0, 0, 0, 0); push(3'b000, 0, 0, 3, 0);
    push(3'b001, 1, 1, 2, 0); burst(3, 1); gap(3, 3);
    push(3'b001, 0, 1, 3, 0); burst(3, 0); gap(3, 2);
    run("qmax_launch");
    do_reset();
    push(3'b001, 0, 0, 0, 0); push(3'b000, 0, 0, 1, 0);
    burst(0, 0); push(3'b010, 0, 1, 0, 0); gap(1, 3); burst(0, 0); gap(0, 4); idle(2);
    run("gap_press");
    do_reset();
    push(3'b001, 0, 0, 0, 0); push(3'b100, 0, 0, 1, 0);
    burst(1, 0); gap(1, 4); burst(0, 0); gap(0, 4); idle(2);
    run("launch_arrive");
    do_reset();
    push(3'b111, 0, 0, 0, 0); push(3'b000, 0, 0, 3, 0);
    run("rst_pre");
    @(posedge clk);
    #2 check("rst_mid_before", {beep_out, busy, pend_cnt, drop}, {1'b1, 1'b1, 2'd2, 1'b0});
    rst = 1'b1;
    #1 check("rst_mid_async", {beep_out, busy, pend_cnt, drop}, 5'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("rst_quiet cyc%0d", i), {beep_out, busy, pend_cnt, drop}, 5'b0);
    end
    push(3'b010, 0, 0, 0, 0); push(3'b000, 0, 0, 1, 0); burst(0, 0); gap(0, 4); idle(1);
    run("rst_after");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_beep.md
Name: key_beep

Overview:
- Output-side counterpart to the key pulse generator: consumes single-cycle key-press pulses and drives a piezo buzzer with one fixed-length tone burst per press.
- Presses arriving during a burst are queued in a saturating pending counter and played back-to-back, separated by a silent gap.
- Sits between the key pulse stage and the board buzzer pin, and gives audible confirmation of each key press to the time-logger user.

Parameters:
- TONE_DIV, 12500: clk cycles per tone half-period (2 kHz at 50 MHz).
- BEEP_CYC, 5000000: clk cycles per tone burst (100 ms).
- GAP_CYC, 2500000: clk cycles of silence between queued bursts (50 ms).
- QMAX, 3: maximum pending presses; must be >=1.
- QW, 2: pending counter width; must satisfy 2^QW > QMAX.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key1_in  in  1  single-cycle press pulse, key 1
- key2_in  in  1  single-cycle press pulse, key 2
- key3_in  in  1  single-cycle press pulse, key 3
- beep_out  out  1  buzzer drive (square wave during burst, else 0)
- busy  out  1  high in BEEP or GAP state
- pend_cnt  out  QW  presses queued and not yet started
- drop  out  1  one-cycle pulse: at least one press discarded due to saturation

Behaviour:
- Reset (async, rst=1): state=IDLE, pend_cnt=0, beep_out=0, busy=0, drop=0, all counters 0.
- Arrivals per cycle: a = key1_in + key2_in + key3_in (0..3). Simultaneous pulses each count.
- Launch (L=1) occurs when either:
  - state=IDLE and pend_cnt>0; or
  - state=GAP, on the last GAP cycle, and pend_cnt>0.
- Launch uses the registered pend_cnt only. Same-cycle arrivals cannot launch.
- Pending update each cycle: s = pend_cnt + a - L.
  - pend_cnt <= min(s, QMAX).
  - drop <= (s > QMAX).
  - Compute s in at least QW+2 bits; no wrap.
- FSM states: IDLE, BEEP, GAP.
  - IDLE: on L -> BEEP; else stay.
  - BEEP: duration counter runs 0..BEEP_CYC-1; at BEEP_CYC-1 -> GAP.
  - GAP: counter runs 0..GAP_CYC-1; at GAP_CYC-1 -> BEEP if L, else IDLE.
  - The duration counter clears on every state entry.
- Tone generation:
  - On entry to BEEP, beep_out <= 1 and the tone counter clears.
  - Within BEEP, beep_out toggles every TONE_DIV cycles.
  - In IDLE and GAP, beep_out <= 0. It is registered and glitch-free.
- Latency: a press pulse in cycle n (state IDLE, pend_cnt=0) gives pend_cnt=1 in cycle n+1, then state=BEEP and beep_out=1 in cycle n+2 with pend_cnt back to 0.
- busy is registered, and equals (state != IDLE).
- Boundaries:
  - A press arriving in the same cycle as a launch is queued, not merged: 1 -> 1 - 1 + 1 = 1.
  - Saturation: 3 pulses while pend_cnt=2 and no launch -> pend_cnt=3, drop=1 for exactly one cycle.
  - At pend_cnt=QMAX, simultaneous launch and one arrival -> no drop.
  - Presses arriving during BEEP or GAP never shorten or restart the current burst.
  - Reset mid-burst forces beep_out=0 immediately, independent of clk.
- Counter widths: each sized to hold its parameter value - 1 (use $clog2, minimum 1).

Decomposition:
- Shared package holds the FSM state enum (IDLE, BEEP, GAP) and default timing constants at 50 MHz: TONE_DIV, BEEP_CYC, GAP_CYC.
- One sub-module: key_beep_tone, the tone divider. It is a TONE_DIV half-period toggle with a synchronous clear-to-high input and an enable input. key_beep instantiates it, gated by state==BEEP.

Test Plan:
All scenarios use test parameters TONE_DIV=2, BEEP_CYC=8, GAP_CYC=4, QMAX=3.
1. Single press:
   - Stimulus: key1_in pulse at cycle 10.
   - Response: pend_cnt=1 at cycle 11. BEEP cycles 12-19, beep_out=1,1,0,0,1,1,0,0. GAP cycles 20-23. IDLE at 24, busy=0. drop never asserted.
2. Simultaneous press:
   - Stimulus: key1, key2 and key3 pulsed in the same cycle while IDLE.
   - Response: pend_cnt=3. Three bursts play back-to-back, each followed by a 4-cycle gap. pend_cnt sequence 3,2,1,0. drop=0.
3. Saturation:
   - Stimulus: while in BEEP with pend_cnt=2, pulse all three keys in one cycle.
   - Response: pend_cnt=3 and drop=1 for exactly one cycle. Exactly 3 further bursts follow.
4. Press during gap:
   - Stimulus: key2 pulse in the first GAP cycle with pend_cnt=0.
   - Response: next BEEP starts right after the 4th GAP cycle. No IDLE cycle in between.
5. Launch plus arrival:
   - Stimulus: key3 pulse in the cycle where IDLE launches from pend_cnt=1.
   - Response: pend_cnt stays 1. A second burst follows the gap.
6. Reset mid-burst:
   - Stimulus: rst asserted mid-cycle during BEEP with beep_out=1 and pend_cnt=2.
   - Response: beep_out, busy and pend_cnt go to 0 immediately without a clk edge. No burst after rst releases until a new press arrives.
